// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for writeback_unit (optional macro WB_MISALIGN_TRAP_EN)
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    // Byte loads never misalign; halfwords need offset[0]=0; every other
    // funct3 behaves as a word load and needs offset[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = off[0];
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load lane select and sign/zero extension
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] aligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte lane and the halfword lane (bit 1 of offset only).
    always_comb begin
        w_byte = rdata[7:0];
        case (offset)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane; unlisted funct3 codes pass the whole word.
    always_comb begin
        aligned = rdata;
        case (funct3)
            F3_LB:   aligned = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   aligned = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LBU:  aligned = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  aligned = {{(XLEN-16){1'b0}}, w_half};
            default: aligned = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register-file writer with load alignment and instret (optional macro WB_MISALIGN_TRAP_EN)
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [4:0]           wb_rd,
    input  logic [1:0]           wb_src,
    input  logic [2:0]           wb_funct3,
    input  logic [XLEN-1:0]      wb_alu,
    input  logic [XLEN-1:0]      wb_pc4,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic [4:0]           rd_addr,
    output logic [XLEN-1:0]      rd_data,
    output logic                 reg_write_enable,
`ifdef WB_MISALIGN_TRAP_EN
    output logic                 trap_misaligned,
`endif
    output logic [INSTRET_W-1:0] instret
);

    wb_state_e       r_state;
    wb_state_e       w_state_nxt;
    logic [4:0]      r_rd;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic            w_capture;
    logic            w_retire;
    logic            w_write;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;
    logic [XLEN-1:0] w_aligned;
`ifdef WB_MISALIGN_TRAP_EN
    logic            r_mis;
    logic            w_trap;
`endif

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata   (mem_rdata),
        .offset  (r_off),
        .funct3  (r_f3),
        .aligned (w_aligned)
    );

    assign wb_ready = (r_state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and the write/retire decision for this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        w_write     = 1'b0;
        w_addr      = wb_rd;
        w_data      = wb_alu;
`ifdef WB_MISALIGN_TRAP_EN
        w_trap      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (wb_valid) begin
                    case (wb_src_e'(wb_src))
                        WB_ALU: begin
                            w_retire = 1'b1;
                            w_write  = 1'b1;
                            w_data   = wb_alu;
                        end
                        WB_PC4: begin
                            w_retire = 1'b1;
                            w_write  = 1'b1;
                            w_data   = wb_pc4;
                        end
                        WB_LOAD: begin
                            w_capture   = 1'b1;
                            w_state_nxt = LOAD_WAIT;
                        end
                        default: w_retire = 1'b1;
                    endcase
                end
            end
            LOAD_WAIT: begin
                w_addr = r_rd;
                w_data = w_aligned;
                if (mem_rvalid) begin
                    w_state_nxt = IDLE;
`ifdef WB_MISALIGN_TRAP_EN
                    if (r_mis) begin
                        w_trap = 1'b1;
                    end else begin
                        w_retire = 1'b1;
                        w_write  = 1'b1;
                    end
`else
                    w_retire = 1'b1;
                    w_write  = 1'b1;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Hold the load's destination, type and byte offset across the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= 5'd0;
            r_f3  <= 3'd0;
            r_off <= 2'd0;
`ifdef WB_MISALIGN_TRAP_EN
            r_mis <= 1'b0;
`endif
        end else if (w_capture) begin
            r_rd  <= wb_rd;
            r_f3  <= wb_funct3;
            r_off <= wb_alu[1:0];
`ifdef WB_MISALIGN_TRAP_EN
            r_mis <= is_misaligned(wb_funct3, wb_alu[1:0]);
`endif
        end
    end

    // Registered write port and retire counter; x0 writes are suppressed but still retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr          <= 5'd0;
            rd_data          <= '0;
            reg_write_enable <= 1'b0;
            instret          <= '0;
`ifdef WB_MISALIGN_TRAP_EN
            trap_misaligned  <= 1'b0;
`endif
        end else begin
            reg_write_enable <= w_write && (w_addr != 5'd0);
            if (w_write) begin
                rd_addr <= w_addr;
                rd_data <= w_data;
            end
            if (w_retire) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
`ifdef WB_MISALIGN_TRAP_EN
            trap_misaligned  <= w_trap;
`endif
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - scoreboard testbench for writeback_unit (optional macro WB_MISALIGN_TRAP_EN)
module tb_writeback_unit;

    localparam int XLEN = 32;
    localparam int IW   = 64;

    localparam logic [1:0] S_ALU  = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_PC4  = 2'b10;
    localparam logic [1:0] S_NONE = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_valid = 1'b0;
    logic            wb_ready;
    logic [4:0]      wb_rd = '0;
    logic [1:0]      wb_src = '0;
    logic [2:0]      wb_funct3 = '0;
    logic [XLEN-1:0] wb_alu = '0;
    logic [XLEN-1:0] wb_pc4 = '0;
    logic            mem_rvalid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            reg_write_enable;
    logic [IW-1:0]   instret;
`ifdef WB_MISALIGN_TRAP_EN
    logic            trap_misaligned;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n_writes = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;

    writeback_unit #(.XLEN(XLEN), .INSTRET_W(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_rd            (wb_rd),
        .wb_src           (wb_src),
        .wb_funct3        (wb_funct3),
        .wb_alu           (wb_alu),
        .wb_pc4           (wb_pc4),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .reg_write_enable (reg_write_enable),
`ifdef WB_MISALIGN_TRAP_EN
        .trap_misaligned  (trap_misaligned),
`endif
        .instret          (instret)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && reg_write_enable) begin
            n_writes++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got x%0d=%h, required no write", rd_addr, rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rd_addr, rd_data} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL write_data: got x%0d=%h, required x%0d=%h",
                             rd_addr, rd_data, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        wb_valid   = 1'b0;
        mem_rvalid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept(input logic [1:0] src, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] pc4);
        int waited;
        wb_src    = src;
        wb_rd     = rd;
        wb_funct3 = f3;
        wb_alu    = alu;
        wb_pc4    = pc4;
        wb_valid  = 1'b1;
        waited    = 0;
        while (wb_ready !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: wb_ready=%b, required 1 within 20 cycles", wb_ready);
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic mem_resp(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({rd_addr, rd_data, reg_write_enable, wb_ready} !== {5'd0, 32'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs: rd_addr=%0d rd_data=%h we=%b ready=%b, required 0 0 0 1",
                     rd_addr, rd_data, reg_write_enable, wb_ready);
        end
        n_vec++;
        if (instret !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_instret: got %0d, required 0", instret);
        end
    endtask

    task automatic test_alu();
        do_reset();
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        accept(S_ALU, 5'd5, 3'd0, 32'hDEADBEEF, 32'h0);
        n_vec++;
        if (reg_write_enable !== 1'b1 || instret !== 64'd1) begin
            n_bad++;
            $display("FAIL alu_write: we=%b instret=%0d, required we=1 instret=1", reg_write_enable, instret);
        end
        idle_cycles(1);
        n_vec++;
        if (reg_write_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL alu_we_pulse: we=%b, required 0 one cycle later", reg_write_enable);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = n_writes;
        exp_q.push_back({5'd1, 32'h00000104});
        wb_src = S_PC4; wb_rd = 5'd1; wb_pc4 = 32'h104; wb_alu = 32'h55; wb_valid = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (wb_ready !== 1'b1 || instret !== 64'd1) begin
            n_bad++;
            $display("FAIL b2b_first: ready=%b instret=%0d, required ready=1 instret=1", wb_ready, instret);
        end
        wb_src = S_NONE; wb_rd = 5'd3;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        n_vec++;
        if (wb_ready !== 1'b1 || instret !== 64'd2) begin
            n_bad++;
            $display("FAIL b2b_second: ready=%b instret=%0d, required ready=1 instret=2", wb_ready, instret);
        end
        idle_cycles(2);
        n_vec++;
        if (n_writes != base + 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_write_count: got %0d writes, required 1", n_writes - base);
        end
    endtask

    task automatic test_load_sign();
        int base;
        logic busy_ok;
        do_reset();
        base = n_writes;
        mem_resp(32'hFFFFFFFF);
        idle_cycles(1);
        n_vec++;
        if (n_writes != base || wb_ready !== 1'b1 || instret !== 64'd0) begin
            n_bad++;
            $display("FAIL idle_rvalid: writes=%0d ready=%b instret=%0d, required 0 1 0",
                     n_writes - base, wb_ready, instret);
        end
        exp_q.push_back({5'd9, 32'hFFFFFF80});
        accept(S_LOAD, 5'd9, 3'b000, 32'h00001003, 32'h0);
        busy_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (wb_ready !== 1'b0 || reg_write_enable !== 1'b0) busy_ok = 1'b0;
            idle_cycles(1);
        end
        n_vec++;
        if (busy_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL lb_wait_ready: ready/we seen high during wait, required 0");
        end
        mem_resp(32'h80112233);
        n_vec++;
        if (reg_write_enable !== 1'b1 || instret !== 64'd1 || wb_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL lb_complete: we=%b instret=%0d ready=%b, required 1 1 1",
                     reg_write_enable, instret, wb_ready);
        end
        exp_q.push_back({5'd10, 32'h00000080});
        accept(S_LOAD, 5'd10, 3'b100, 32'h00001003, 32'h0);
        idle_cycles(4);
        mem_resp(32'h80112233);
        n_vec++;
        if (reg_write_enable !== 1'b1 || instret !== 64'd2) begin
            n_bad++;
            $display("FAIL lbu_complete: we=%b instret=%0d, required 1 2", reg_write_enable, instret);
        end
        idle_cycles(1);
    endtask

    task automatic test_lhu_rd0();
        int base;
        do_reset();
        base = n_writes;
        exp_q.push_back({5'd7, 32'h0000ABCD});
        accept(S_LOAD, 5'd7, 3'b101, 32'h00002002, 32'h0);
        idle_cycles(1);
        mem_resp(32'hABCD0000);
        n_vec++;
        if (instret !== 64'd1) begin
            n_bad++;
            $display("FAIL lhu_instret: got %0d, required 1", instret);
        end
        accept(S_LOAD, 5'd0, 3'b101, 32'h00002002, 32'h0);
        mem_resp(32'hABCD0000);
        n_vec++;
        if (reg_write_enable !== 1'b0 || instret !== 64'd2) begin
            n_bad++;
            $display("FAIL rd0_load: we=%b instret=%0d, required we=0 instret=2", reg_write_enable, instret);
        end
        accept(S_ALU, 5'd0, 3'd0, 32'h12345678, 32'h0);
        idle_cycles(1);
        n_vec++;
        if (n_writes != base + 1 || instret !== 64'd3) begin
            n_bad++;
            $display("FAIL rd0_alu: writes=%0d instret=%0d, required 1 3", n_writes - base, instret);
        end
    endtask

    task automatic test_word_and_trunc();
        do_reset();
        exp_q.push_back({5'd6, 32'hCAFEF00D});
        accept(S_LOAD, 5'd6, 3'b011, 32'h00003000, 32'h0);
        mem_resp(32'hCAFEF00D);
        exp_q.push_back({5'd8, 32'h00001234});
        accept(S_LOAD, 5'd8, 3'b101, 32'h00003002, 32'h0);
        mem_resp(32'h12348001);
`ifndef WB_MISALIGN_TRAP_EN
        exp_q.push_back({5'd4, 32'hFFFF8001});
        accept(S_LOAD, 5'd4, 3'b001, 32'h00003001, 32'h0);
        mem_resp(32'h12348001);
`endif
        idle_cycles(1);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL word_trunc_pending: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_load();
        int base;
        do_reset();
        base = n_writes;
        accept(S_LOAD, 5'd11, 3'b000, 32'h00000000, 32'h0);
        idle_cycles(2);
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (wb_ready !== 1'b1 || reg_write_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: ready=%b we=%b, required 1 0", wb_ready, reg_write_enable);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_resp(32'h00000011);
        idle_cycles(1);
        n_vec++;
        if (instret !== 64'd0 || n_writes != base || wb_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_load: instret=%0d writes=%0d ready=%b, required 0 0 1",
                     instret, n_writes - base, wb_ready);
        end
    endtask

`ifdef WB_MISALIGN_TRAP_EN
    task automatic test_misalign();
        do_reset();
        accept(S_LOAD, 5'd12, 3'b010, 32'h00001001, 32'h0);
        idle_cycles(1);
        mem_resp(32'h11223344);
        n_vec++;
        if (trap_misaligned !== 1'b1 || reg_write_enable !== 1'b0 || instret !== 64'd0) begin
            n_bad++;
            $display("FAIL misalign_trap: trap=%b we=%b instret=%0d, required 1 0 0",
                     trap_misaligned, reg_write_enable, instret);
        end
        idle_cycles(1);
        n_vec++;
        if (trap_misaligned !== 1'b0 || wb_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_pulse: trap=%b ready=%b, required 0 1", trap_misaligned, wb_ready);
        end
        exp_q.push_back({5'd13, 32'h00001122});
        accept(S_LOAD, 5'd13, 3'b101, 32'h00001002, 32'h0);
        mem_resp(32'h11223344);
        n_vec++;
        if (trap_misaligned !== 1'b0 || instret !== 64'd1) begin
            n_bad++;
            $display("FAIL aligned_no_trap: trap=%b instret=%0d, required 0 1", trap_misaligned, instret);
        end
        idle_cycles(1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_sign();
        test_lhu_rd0();
        test_word_and_trunc();
        test_reset_load();
`ifdef WB_MISALIGN_TRAP_EN
        test_misalign();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d writes never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the CPU register file.
- Accepts completed instructions from the execute stage and selects the result source: ALU, load data or PC+4.
- For loads, waits on the data-memory read response, then aligns and sign/zero-extends the data.
- Drives the register-file write port (rd_addr, rd_data, reg_write_enable) and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, data width of results and memory read data.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  execute stage presents an instruction.
- wb_ready  out  1  unit can accept; transfer occurs when wb_valid && wb_ready.
- wb_rd  in  5  destination register index.
- wb_src  in  2  result source: 00 ALU, 01 LOAD, 10 PC4, 11 NONE (no write).
- wb_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- wb_alu  in  XLEN  ALU result; for loads this is the effective address.
- wb_pc4  in  XLEN  PC+4, for JAL/JALR.
- mem_rvalid  in  1  single-cycle pulse, read data valid.
- mem_rdata  in  XLEN  word-aligned read data.
- rd_addr  out  5  register-file write index.
- rd_data  out  XLEN  register-file write data.
- reg_write_enable  out  1  register-file write strobe, one cycle per write.
- instret  out  INSTRET_W  count of retired instructions.
- trap_misaligned  out  1  present only with WB_MISALIGN_TRAP_EN.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE; rd_addr 0; rd_data 0; reg_write_enable 0; instret 0; trap_misaligned 0. wb_ready is 1 in IDLE.
- All outputs are registered.
- FSM states: IDLE, LOAD_WAIT.
- IDLE:
  - wb_ready=1.
  - On accept with wb_src ALU or PC4: next cycle, rd_data is wb_alu or wb_pc4, rd_addr=wb_rd, and reg_write_enable=1 for exactly one cycle. Latency is 1 cycle. Stay in IDLE, so throughput is one instruction per cycle.
  - On accept with wb_src NONE: no write; instret increments.
  - On accept with wb_src LOAD: capture wb_rd, wb_funct3 and wb_alu[1:0], then go to LOAD_WAIT.
- LOAD_WAIT:
  - wb_ready=0.
  - On mem_rvalid: select the byte or half lane using the captured offset, then extend.
    - LB / LH sign-extend.
    - LBU / LHU zero-extend.
    - LW passes the word.
    - funct3 011, 110 and 111 are treated as LW.
  - The next cycle asserts reg_write_enable with the aligned data, and the FSM returns to IDLE.
  - Load latency is 1 cycle after mem_rvalid.
  - No timeout.
- rd==0: reg_write_enable is forced 0. The instruction still retires and instret still increments.
- instret increments by 1 in the cycle the write (or retire-without-write) is presented. It wraps at 2^INSTRET_W.
- mem_rvalid in IDLE is ignored; no state change.
- wb_valid in LOAD_WAIT is not accepted. Upstream holds its inputs until accept.
- Reset in LOAD_WAIT abandons the pending load: no write, and no instret increment.
- Lane selection for LH/LHU uses offset bit 1 only. Bit 0 is ignored unless the optional trap feature is compiled in.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- With the macro:
  - At accept, a LOAD is misaligned if: LH/LHU with offset[0]=1, or LW with offset[1:0]!=0.
  - A misaligned load still goes to LOAD_WAIT.
  - On mem_rvalid: reg_write_enable stays 0, trap_misaligned pulses 1 for one cycle, and instret does not increment.
- Without the macro: the trap_misaligned port is absent and misaligned offsets are truncated as described above.

Decomposition:
- Package wb_pkg:
  - wb_src_e enum (WB_ALU, WB_LOAD, WB_PC4, WB_NONE).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state_e (IDLE, LOAD_WAIT).
- Sub-module load_align: combinational lane select and extend. Inputs: rdata, offset[1:0], funct3. Output: aligned XLEN word.

Test Plan:
- Reset then accept ALU, rd=5, wb_alu=0xDEADBEEF -> next cycle reg_write_enable=1, rd_addr=5, rd_data=0xDEADBEEF; instret=1.
- Back-to-back accepts PC4 (rd=1, pc4=0x104) then NONE -> write of 0x104 to x1, then no write; instret=2; wb_ready held 1.
- LB with offset 3, mem_rdata=0x80112233 after 4-cycle wait -> wb_ready=0 during the wait; rd_data=0xFFFFFF80. Repeat with LBU -> rd_data=0x00000080.
- LHU with offset 2, mem_rdata=0xABCD0000 -> rd_data=0x0000ABCD. Same instruction with rd=0 -> no write, instret still increments.
- Assert rst_n low mid-LOAD_WAIT, then pulse mem_rvalid -> no write, instret=0, state IDLE.
- With WB_MISALIGN_TRAP_EN, LW at offset 1 -> on mem_rvalid, trap_misaligned pulses 1, no write, instret unchanged.
